// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB has absolute priority, auxiliary writes
// queue in a small FIFO and drain into idle slots, with hazard and starvation reporting.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_dest,
    input  logic [DATA_W-1:0] aux_value,
    output logic              rf_wb_en,
    output logic [ADDR_W-1:0] rf_wb_dest,
    output logic [DATA_W-1:0] rf_wb_value,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              two_src,
    output logic              pending_hazard,
    output logic              stall_req,
    output logic [CNT_W-1:0]  fifo_count
);

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [7:0]        starve_reg;

    logic [DEPTH-1:0]  live_vec;
    logic [DEPTH-1:0]  hit_vec;
    logic [ADDR_W-1:0] dest_arr [DEPTH];
    logic [DATA_W-1:0] value_mem [DEPTH];

    logic push;
    logic pop;
    logic rf_hit;

    assign aux_ready  = (count_reg != CNT_W'(DEPTH));
    assign push       = aux_valid && aux_ready;
    assign pop        = !wb_en && (count_reg != '0);
    assign fifo_count = count_reg;

    // Live bit and dest per entry stay in flops: every entry is compared against
    // the sources and against wb_dest in the same cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic              live_reg;
            logic [ADDR_W-1:0] dest_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    live_reg <= 1'b0;
                    dest_reg <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    // A same-cycle push is younger than the WB write and stays live.
                    live_reg <= 1'b1;
                    dest_reg <= aux_dest;
                end else if ((pop && (rd_ptr_reg == PTR_W'(gi))) ||
                             (wb_en && live_reg && (dest_reg == wb_dest))) begin
                    live_reg <= 1'b0;
                end
            end

            assign live_vec[gi] = live_reg;
            assign dest_arr[gi] = dest_reg;
            assign hit_vec[gi]  = live_reg &&
                                  ((dest_reg == src1) || (two_src && (dest_reg == src2)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            value_mem[wr_ptr_reg] <= aux_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // A squashed head still consumes its slot but issues with the enable low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wb_en    <= 1'b0;
            rf_wb_dest  <= '0;
            rf_wb_value <= '0;
        end else if (wb_en) begin
            rf_wb_en    <= 1'b1;
            rf_wb_dest  <= wb_dest;
            rf_wb_value <= wb_value;
        end else if (pop) begin
            rf_wb_en    <= live_vec[rd_ptr_reg];
            rf_wb_dest  <= dest_arr[rd_ptr_reg];
            rf_wb_value <= value_mem[rd_ptr_reg];
        end else begin
            rf_wb_en    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else if ((count_reg == '0) || pop) begin
            starve_reg <= '0;
        end else if (starve_reg != 8'hFF) begin
            starve_reg <= starve_reg + 1'b1;
        end
    end

    assign stall_req = (starve_reg >= 8'(STARVE_LIMIT));

    assign rf_hit = rf_wb_en &&
                    ((rf_wb_dest == src1) || (two_src && (rf_wb_dest == src2)));
    assign pending_hazard = (|hit_vec) || rf_hit;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are queued
// as stimulus is driven and checked whenever the DUT issues a write.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        aux_valid;
    logic        aux_ready;
    logic [3:0]  aux_dest;
    logic [31:0] aux_value;
    logic        rf_wb_en;
    logic [3:0]  rf_wb_dest;
    logic [31:0] rf_wb_value;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        pending_hazard;
    logic        stall_req;
    logic [2:0]  fifo_count;

    typedef struct packed {
        logic [3:0]  d;
        logic [31:0] v;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(4), .DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_dest(aux_dest), .aux_value(aux_value),
        .rf_wb_en(rf_wb_en), .rf_wb_dest(rf_wb_dest), .rf_wb_value(rf_wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pending_hazard(pending_hazard), .stall_req(stall_req),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] wd, input logic [31:0] wv,
                         input logic av, input logic [3:0] ad, input logic [31:0] avv);
        wb_en     = we;
        wb_dest   = wd;
        wb_value  = wv;
        aux_valid = av;
        aux_dest  = ad;
        aux_value = avv;
    endtask

    task automatic expect_wr(input logic [3:0] d, input logic [31:0] v);
        wr_t e;
        e.d = d;
        e.v = v;
        exp_q.push_back(e);
    endtask

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rf_wb_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_write: observed dest %0h value %0h expected no write",
                       rf_wb_dest, rf_wb_value);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rf_write", {28'd0, rf_wb_dest, rf_wb_value}, {28'd0, e.d, e.v});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        src1 = 4'd0; src2 = 4'd0; two_src = 1'b1;
        tick();
        tick();
        check("rst_aux_ready", aux_ready, 1);
        check("rst_hazard", pending_hazard, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rf_en", rf_wb_en, 0);
        check("rst_rf_dest", rf_wb_dest, 0);
        check("rst_rf_value", rf_wb_value, 0);
        check("rst_stall", stall_req, 0);
        rst = 1'b0;
        src1 = 4'd2; src2 = 4'd2; two_src = 1'b0;

        // WB write, one cycle latency
        drive(1, 3, 32'h1234, 0, 0, 0);
        expect_wr(3, 32'h1234);
        tick();
        check("wb_en_out", rf_wb_en, 1);
        check("wb_dest_out", rf_wb_dest, 3);
        check("wb_value_out", rf_wb_value, 32'h1234);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("wb_en_drop", rf_wb_en, 0);

        // Single aux write, two cycle latency
        drive(0, 0, 0, 1, 5, 32'hAA);
        expect_wr(5, 32'hAA);
        tick();
        check("aux_count1", fifo_count, 1);
        check("aux_en_wait", rf_wb_en, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("aux_en_out", rf_wb_en, 1);
        check("aux_dest_out", rf_wb_dest, 5);
        check("aux_value_out", rf_wb_value, 32'hAA);
        check("aux_count0", fifo_count, 0);

        // Fill under continuous WB, starvation, then ordered drain
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h100 + k, 1, 4'(10 + k), 32'h200 + k);
            expect_wr(1, 32'h100 + k);
            tick();
        end
        check("full_count", fifo_count, 4);
        check("full_ready", aux_ready, 0);
        check("full_stall_early", stall_req, 0);
        for (int j = 0; j < 4; j++) begin
            drive(1, 1, 32'h300 + j, 1, 14, 32'hEE);
            expect_wr(1, 32'h300 + j);
            tick();
        end
        check("stall_before_limit", stall_req, 0);
        check("full_ignore_count", fifo_count, 4);
        drive(1, 1, 32'h400, 1, 14, 32'hEE);
        expect_wr(1, 32'h400);
        tick();
        check("stall_at_limit", stall_req, 1);
        drive(0, 0, 0, 0, 0, 0);
        expect_wr(10, 32'h200);
        tick();
        check("drain0_dest", rf_wb_dest, 10);
        check("drain0_count", fifo_count, 3);
        check("stall_cleared", stall_req, 0);
        for (int k = 1; k < 4; k++) begin
            expect_wr(4'(10 + k), 32'h200 + k);
            tick();
            check("drain_en", rf_wb_en, 1);
            check("drain_dest", rf_wb_dest, 10 + k);
        end
        check("drain_count0", fifo_count, 0);

        // Squash of an older entry; same-cycle younger push survives
        drive(0, 0, 0, 1, 7, 32'h77);
        tick();
        check("sq_count1", fifo_count, 1);
        drive(1, 7, 32'h7777, 1, 7, 32'h99);
        expect_wr(7, 32'h7777);
        tick();
        check("sq_wb_value", rf_wb_value, 32'h7777);
        check("sq_count2", fifo_count, 2);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("sq_slot_en", rf_wb_en, 0);
        check("sq_count_after", fifo_count, 1);
        expect_wr(7, 32'h99);
        tick();
        check("young_en", rf_wb_en, 1);
        check("young_value", rf_wb_value, 32'h99);
        check("young_count0", fifo_count, 0);

        // Hazard detection against FIFO and output register
        drive(1, 15, 32'h5555, 1, 9, 32'h9999);
        expect_wr(15, 32'h5555);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        src1 = 4'd9; src2 = 4'd2; two_src = 1'b0;
        #1 check("haz_src1", pending_hazard, 1);
        src1 = 4'd2; src2 = 4'd9; two_src = 1'b0;
        #1 check("haz_src2_dead", pending_hazard, 0);
        two_src = 1'b1;
        #1 check("haz_src2_live", pending_hazard, 1);
        src1 = 4'd15; src2 = 4'd2; two_src = 1'b0;
        #1 check("haz_rf", pending_hazard, 1);
        src1 = 4'd2; src2 = 4'd3; two_src = 1'b1;
        #1 check("haz_none", pending_hazard, 0);

        // Reset with queued entries discards them
        drive(1, 15, 32'h5556, 1, 4, 32'h44);
        expect_wr(15, 32'h5556);
        tick();
        drive(1, 15, 32'h5557, 1, 5, 32'h55);
        expect_wr(15, 32'h5557);
        tick();
        check("pre_rst_count", fifo_count, 3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        src1 = 4'd9; src2 = 4'd4; two_src = 1'b1;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_en", rf_wb_en, 0);
        check("mid_rst_stall", stall_req, 0);
        check("mid_rst_ready", aux_ready, 1);
        check("mid_rst_hazard", pending_hazard, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("post_rst_count", fifo_count, 0);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the register file. The pipeline WB stage and an auxiliary multi-cycle producer (SRAM/load return path) both need the register file's single write port. WB always wins. Auxiliary writes are buffered in a small FIFO and drained into idle write slots. The block also reports pending-write hazards to ID and raises a freeze request when the FIFO starves.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 4, register address width
- DEPTH, 4, auxiliary FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive blocked cycles before stall_req (1..255)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_en  in  1  WB stage write request (never back-pressured)
- wb_dest  in  ADDR_W  WB destination register
- wb_value  in  DATA_W  WB write data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  FIFO can accept; transfer when aux_valid & aux_ready
- aux_dest  in  ADDR_W  auxiliary destination
- aux_value  in  DATA_W  auxiliary data
- rf_wb_en  out  1  register-file write enable (registered)
- rf_wb_dest  out  ADDR_W  register-file write address (registered)
- rf_wb_value  out  DATA_W  register-file write data (registered)
- src1, src2  in  ADDR_W  ID source registers
- two_src  in  1  src2 is a live operand
- pending_hazard  out  1  an ID source matches a pending write
- stall_req  out  1  freeze request to pipeline (stops new WB traffic)
- fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries

## Operation
- FIFO entry: {live, dest, value}. Push writes live=1.
- aux_ready = (fifo_count != DEPTH). It depends only on registered state, never on the same-cycle pop.
- Slot selection, each cycle:
  - wb_en=1: output register loads {1, wb_dest, wb_value}; no pop.
  - wb_en=0 and FIFO non-empty: pop head. Output register loads {head.live, head.dest, head.value}.
  - Otherwise: rf_wb_en loads 0. dest/value hold their previous value.
- Ordering: when wb_en=1, every live FIFO entry with dest == wb_dest is squashed (live←0) that cycle. An entry pushed in the same cycle with the same dest is younger and stays live.
- A squashed head is still popped in a free slot, with rf_wb_en=0. It costs one slot.
- Simultaneous push and pop: both occur and fifo_count is unchanged. A push to an empty FIFO is not popped in the same cycle.
- pending_hazard (combinational) is set when either of these matches src1, or matches src2 while two_src=1:
  - any live FIFO entry's dest;
  - rf_wb_dest while rf_wb_en=1.
- Starvation counter (8 bits):
  - clears when the FIFO is empty or a pop occurs;
  - otherwise increments, saturating at 255.
- stall_req = (counter ≥ STARVE_LIMIT). It drops the cycle after the pop that clears the counter.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, all live bits 0, pointers 0, counter 0. rf_wb_en=0, rf_wb_dest=0, rf_wb_value=0, stall_req=0, fifo_count=0.
- Outputs during reset: aux_ready=1. pending_hazard=0 for any sources.
- Reset mid-operation discards all buffered entries; no write is issued after rst.
- Latency:
  - WB request to rf_wb_*: 1 cycle.
  - Aux push to rf_wb_* when the FIFO was empty and wb_en stays low: 2 cycles (push at edge N, pop at edge N+1).
- Full: aux_valid with aux_ready=0 is ignored; the producer holds its data.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- FIFO drain order equals push order.

## Test plan
- Reset, then wb_en=1, wb_dest=3, wb_value=0x1234 for one cycle -> next cycle rf_wb_en=1, dest=3, value=0x1234; the cycle after, rf_wb_en=0.
- wb_en=0, push aux dest=5, value=0xAA -> fifo_count=1 for one cycle, then rf_wb_en=1, dest=5, value=0xAA; fifo_count returns to 0.
- Hold wb_en=1 and push 4 aux entries -> aux_ready=0 at count 4. stall_req rises STARVE_LIMIT=8 blocked cycles after the first push. Drop wb_en -> entries drain in order on 4 consecutive cycles; stall_req clears after the first pop.
- FIFO holds live dest=7, then wb_en=1 with wb_dest=7 -> entry squashed. When drained, that slot has rf_wb_en=0 and R7 keeps the WB value.
- FIFO holds dest=9; src1=9 -> pending_hazard=1. With src1=2, src2=9: two_src=0 -> pending_hazard=0; two_src=1 -> pending_hazard=1.
- Assert rst with 3 entries queued -> fifo_count=0, rf_wb_en=0, stall_req=0 immediately. No queued write appears after release.
